mmm_modexp_ctrl: RTL and testbench

Sequencer that computes base^expo mod m using one shared radix-2 Montgomery multiplier. It drives the `mmm_r2mm_2n` core through its `req`/`val` port and keeps the operand, accumulator and exponent registers. It runs a fixed-length, constant-time square-and-always-multiply schedule. It sits between the host/CSR layer and the multiplier; a wrapper `mmm_modexp_top` instantiates both.

---
 rtl/mmm_pkg.sv | 34 +++
 rtl/mmm_modexp_ctrl.sv | 143 ++++++++++++++
 tb/tb_mmm_modexp_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mmm_pkg.sv
// Shared types and sizing helpers for the modular-exponentiation controller.
package mmm_pkg;

  localparam int MMM_K   = 256;
  localparam int MMM_E   = 256;
  // Multiplications per job: two conversions, a square and a multiply per
  // exponent bit, and one conversion out of the Montgomery domain.
  localparam int MMM_OPS = 2 * MMM_E + 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    PH_CONV_B = 3'd0,
    PH_CONV_1 = 3'd1,
    PH_SQR    = 3'd2,
    PH_MUL    = 3'd3,
    PH_OUT    = 3'd4
  } phase_t;

  // Bit-index width; at least one bit so E=1 still has a legal register.
  function automatic int idx_w(input int e);
    return (e > 1) ? $clog2(e) : 1;
  endfunction

  function automatic int op_count(input int e);
    return 2 * e + 3;
  endfunction

endpackage

// File: rtl/mmm_modexp_ctrl.sv
// Constant-time square-and-always-multiply sequencer for one shared
// radix-2 Montgomery multiplier. Computes base^expo mod m.
module mmm_modexp_ctrl
  import mmm_pkg::*;
#(
  parameter int K = MMM_K,
  parameter int E = MMM_E
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [K-1:0] base,
  input  logic [E-1:0] expo,
  input  logic [K-1:0] m,
  input  logic [K-1:0] r2,
  output logic         busy,
  output logic         done,
  output logic [K-1:0] res,
  output logic [K-1:0] mm_x,
  output logic [K-1:0] mm_y,
  output logic [K-1:0] mm_m,
  output logic         mm_req,
  input  logic [K-1:0] mm_res,
  input  logic         mm_val
);

  localparam int IW  = idx_w(E);
  localparam int OPS = op_count(E);
  localparam int CW  = $clog2(OPS + 1);

  localparam logic [K-1:0] ONE     = K'(1);
  localparam logic [IW-1:0] IDX_TOP = IW'(E - 1);
  localparam logic [CW-1:0] OP_LAST = CW'(OPS - 1);

  state_t          state, state_nxt;
  phase_t          phase;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   op_cnt;
  logic [K-1:0]    base_r, r2_r, m_r, acc, xm;
  logic [E-1:0]    expo_r;

  logic accept, wb, last_op;

  assign accept  = (state == ST_IDLE) && start;
  // mm_val is only meaningful while a multiplication is outstanding.
  assign wb      = (state == ST_WAIT) && mm_val;
  assign last_op = (op_cnt == OP_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; the WAIT state guarantees a low gap between req pulses
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (mm_val) state_nxt = last_op ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs straight from the state
  always_comb begin
    mm_req = (state == ST_ISSUE);
    busy   = (state == ST_ISSUE) || (state == ST_WAIT);
    done   = (state == ST_DONE);
  end

  // Operand latch, phase/index sequencing and result write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r <= '0;
      r2_r   <= '0;
      m_r    <= '0;
      expo_r <= '0;
      acc    <= '0;
      xm     <= '0;
      res    <= '0;
      phase  <= PH_CONV_B;
      idx    <= '0;
      op_cnt <= '0;
    end else if (accept) begin
      base_r <= base;
      r2_r   <= r2;
      m_r    <= m;
      expo_r <= expo;
      phase  <= PH_CONV_B;
      idx    <= IDX_TOP;
      op_cnt <= '0;
    end else if (wb) begin
      op_cnt <= op_cnt + 1'b1;
      unique case (phase)
        PH_CONV_B: begin
          xm    <= mm_res;
          phase <= PH_CONV_1;
        end
        PH_CONV_1: begin
          acc   <= mm_res;
          phase <= PH_SQR;
        end
        PH_SQR: begin
          acc   <= mm_res;
          phase <= PH_MUL;
        end
        PH_MUL: begin
          // The product is always computed; only its use depends on the bit.
          if (expo_r[idx]) acc <= mm_res;
          if (idx == '0) begin
            phase <= PH_OUT;
          end else begin
            idx   <= idx - 1'b1;
            phase <= PH_SQR;
          end
        end
        PH_OUT: res <= mm_res;
        default: phase <= PH_CONV_B;
      endcase
    end
  end

  // Operand selection; phase only moves on the write-back edge, so the
  // operands hold from ISSUE through the mm_val cycle.
  always_comb begin
    mm_x = base_r;
    mm_y = r2_r;
    unique case (phase)
      PH_CONV_B: begin mm_x = base_r; mm_y = r2_r; end
      PH_CONV_1: begin mm_x = ONE;    mm_y = r2_r; end
      PH_SQR:    begin mm_x = acc;    mm_y = acc;  end
      PH_MUL:    begin mm_x = acc;    mm_y = xm;   end
      PH_OUT:    begin mm_x = acc;    mm_y = ONE;  end
      default:   begin mm_x = base_r; mm_y = r2_r; end
    endcase
  end

  assign mm_m = m_r;

endmodule

// File: tb/tb_mmm_modexp_ctrl.sv
// Directed bench for mmm_modexp_ctrl at K=8, E=4 with a behavioural
// Montgomery multiplier answering K/2+1 cycles after each request.
module tb_mmm_modexp_ctrl;

  localparam int K = 8;
  localparam int E = 4;
  localparam int R = 1 << K;
  localparam int T = K / 2 + 2;
  localparam int LAT = (2 * E + 3) * T + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [K-1:0] base, m, r2;
  logic [E-1:0] expo;
  logic         busy, done, mm_req;
  logic [K-1:0] res, mm_x, mm_y, mm_m;
  logic [K-1:0] mm_res;
  logic         mm_val;

  // behavioural multiplier state
  logic         mdl_busy, mdl_val;
  logic [K-1:0] mdl_res;
  int           mdl_cnt;
  logic         spur_val;
  logic [K-1:0] spur_res;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign mm_val = mdl_val | spur_val;
  assign mm_res = spur_val ? spur_res : mdl_res;

  mmm_modexp_ctrl #(.K(K), .E(E)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .base   (base),
    .expo   (expo),
    .m      (m),
    .r2     (r2),
    .busy   (busy),
    .done   (done),
    .res    (res),
    .mm_x   (mm_x),
    .mm_y   (mm_y),
    .mm_m   (mm_m),
    .mm_req (mm_req),
    .mm_res (mm_res),
    .mm_val (mm_val)
  );

  // x*y*R^-1 mod mm by search: the r with r*R == x*y (mod mm)
  function automatic int mont(input int x, input int y, input int mm);
    for (int r = 0; r < mm; r++)
      if (((r * R) % mm) == ((x * y) % mm)) return r;
    return 0;
  endfunction

  // Multiplier model: request seen at the end of cycle c, val in cycle c+K/2+1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_busy <= 1'b0;
      mdl_val  <= 1'b0;
      mdl_res  <= '0;
      mdl_cnt  <= 0;
    end else begin
      mdl_val <= 1'b0;
      if (mm_req) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= K / 2 - 1;
        mdl_res  <= K'(mont(int'(mm_x), int'(mm_y), int'(mm_m)));
      end else if (mdl_busy) begin
        if (mdl_cnt == 0) begin
          mdl_val  <= 1'b1;
          mdl_busy <= 1'b0;
        end else begin
          mdl_cnt <= mdl_cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launch one job from a point #1 after an edge; returns in the done cycle.
  task automatic run_job(input string tag, input logic [K-1:0] b,
                         input logic [E-1:0] ex, input int exp_res,
                         input bit inject);
    int n, reqs, last, busyc;
    bit gap_ok, got;
    base = b; expo = ex; m = K'(13); r2 = K'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; reqs = 0; last = -100; busyc = 0; gap_ok = 1'b1; got = 1'b0;
    while (n <= 300) begin
      if (mm_req) begin
        if (n - last < T) gap_ok = 1'b0;
        reqs++;
        last = n;
      end
      if (busy) busyc++;
      if (done) begin got = 1'b1; break; end
      if (inject && n == 10) begin
        base = K'(5); expo = E'(7); m = K'(11); start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_latency"}, n, LAT);
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_req_pulses"}, reqs, 2 * E + 3);
    chk({tag, "_req_gap"}, gap_ok, 1);
    chk({tag, "_busy_cycles"}, busyc, LAT - 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base = '0; expo = '0; m = '0; r2 = '0;
    spur_val = 1'b0; spur_res = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", res, 0);
    chk("rst_req", mm_req, 0);
    chk("rst_mm_x", mm_x, 0);
    chk("rst_mm_y", mm_y, 0);
    chk("rst_mm_m", mm_m, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2^10 mod 13 = 10
    run_job("basic", K'(2), E'(4'b1010), 10, 1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("res_held", res, 10);

    // mm_val outside WAIT must not disturb anything
    spur_val = 1'b1; spur_res = K'(99);
    @(posedge clk); #1;
    spur_val = 1'b0;
    @(posedge clk); #1;
    chk("spur_busy", busy, 0);
    chk("spur_res", res, 10);

    run_job("zero_exp", K'(7), E'(0), 1, 1'b0);
    @(posedge clk); #1;
    // 12 = -1 mod 13, odd power
    run_job("ones_exp", K'(12), E'(4'b1111), 12, 1'b0);
    @(posedge clk); #1;

    // start during WAIT ignored; next start right after done accepted
    run_job("start_busy", K'(2), E'(4'b1010), 10, 1'b1);
    @(posedge clk); #1;
    run_job("back2back", K'(5), E'(4'b0011), 8, 1'b0);
    @(posedge clk); #1;

    // reset during op 5 (issued in cycle s+31)
    base = K'(2); expo = E'(4'b1010); m = K'(13); r2 = K'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", mm_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_mm_x", mm_x, 0);
    chk("mid_rst_mm_y", mm_y, 0);
    chk("mid_rst_mm_m", mm_m, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job("after_rst", K'(2), E'(4'b1010), 10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
